// File: rtl/div_seq_32_pkg.sv
// div_seq_32_pkg: shared widths and FSM encoding for the sequential divider
package div_seq_32_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_FIX  = 3'd2,
    S_DONE = 3'd3,
    S_DZ   = 3'd4
  } state_t;
endpackage

// File: rtl/div_seq_32_step.sv
// div_seq_32_step: one combinational restoring-division step
module div_seq_32_step
  import div_seq_32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  // shift {rem,q} left and keep the trial difference only when it does not borrow
  always_comb begin
    shifted  = {rem, q[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    q_next   = {q[WIDTH-2:0], ~trial[WIDTH]};
  end
endmodule

// File: rtl/div_seq_32.sv
// div_seq_32: multi-cycle signed divider, quotient truncated toward zero
module div_seq_32
  import div_seq_32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, result_q, result_d;
  logic               sign_q, sign_d, exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;
  logic [WIDTH-1:0]   rem_nx, quo_nx, a_abs, b_abs;
  div_seq_32_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .q       (quo_q),
    .divisor (dvs_q),
    .rem_next(rem_nx),
    .q_next  (quo_nx)
  );
  // next-state logic: a start overrides whatever is in flight
  always_comb begin
    a_abs    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_abs    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sign_d   = sign_q;
    result_d = result_q;
    exc_d    = exc_q;
    if (ctrl_div) begin
      state_d = |data_operandB ? S_RUN : S_DZ;
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = a_abs;
      dvs_d   = b_abs;
      sign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
    end else if (state_q == S_RUN) begin
      rem_d   = rem_nx;
      quo_d   = quo_nx;
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? S_FIX : S_RUN;
    end else if (state_q == S_FIX) begin
      result_d = sign_q ? -quo_q : quo_q;
      exc_d    = 1'b0;
      state_d  = S_DONE;
    end else if (state_q == S_DZ) begin
      result_d = '0;
      exc_d    = 1'b1;
      state_d  = S_DONE;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
    rdy_d  = state_d == S_DONE;
    busy_d = state_d != S_IDLE;
  end
  // state and registered outputs; reset aborts any divide without a ready pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end
  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_div_seq_32.sv
// tb_div_seq_32: scoreboard bench for the sequential divider
module tb_div_seq_32;
  logic        clock = 1'b0, reset = 1'b1, ctrl_div = 1'b0;
  logic [31:0] a = '0, b = '0, data_result;
  logic        data_exception, data_resultRDY, busy;
  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          rdy_cyc;
  } exp_t;
  exp_t sb[$];
  int   cyc = 0, checks = 0, failures = 0, busy_from = 1, busy_until = 0;
  bit   mon_en = 1'b0;
  div_seq_32 dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_div      (ctrl_div),
    .data_operandA (a),
    .data_operandB (b),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask
  // quotient from plain signed 64-bit arithmetic; latency from start cycle c
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int c);
    exp_t   e;
    longint xs, ys, qq;
    xs = $signed(x);
    ys = $signed(y);
    if (y == 32'd0) begin
      e.res = '0; e.exc = 1'b1; e.rdy_cyc = c + 2;
    end else begin
      qq = xs / ys;
      e.res = qq[31:0]; e.exc = 1'b0; e.rdy_cyc = c + 34;
    end
    return e;
  endfunction
  function automatic bit in_busy(input int c);
    return c >= busy_from && c <= busy_until;
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic start(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e = model(x, y, cyc);
    while (sb.size() != 0 && sb[$].rdy_cyc > cyc) void'(sb.pop_back());
    if (!in_busy(cyc)) busy_from = cyc + 1;
    busy_until = e.rdy_cyc;
    sb.push_back(e);
    a = x; b = y; ctrl_div = 1'b1;
    tick();
    ctrl_div = 1'b0;
  endtask
  task automatic do_reset();
    while (sb.size() != 0 && sb[$].rdy_cyc > cyc) void'(sb.pop_back());
    if (in_busy(cyc)) busy_until = cyc;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL wait_idle timeout cyc=%0d pending=%0d expected=0", cyc, sb.size());
      sb.delete();
    end
    tick();
  endtask
  task automatic wait_rdy();
    for (int i = 0; i < 200 && !(sb.size() != 0 && sb[0].rdy_cyc == cyc); i++) tick();
    if (!(sb.size() != 0 && sb[0].rdy_cyc == cyc)) begin
      checks++; failures++;
      $display("FAIL wait_rdy timeout cyc=%0d pending=%0d", cyc, sb.size());
    end
  endtask
  // monitor: busy every cycle, and each ready pulse against the scoreboard head
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      chk("busy", {31'd0, busy}, {31'd0, in_busy(cyc)});
      if (data_resultRDY === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL rdy_unexpected cyc=%0d actual=1 expected=0", cyc);
        end else begin
          e = sb.pop_front();
          chk("rdy_cycle", cyc, e.rdy_cyc);
          chk("result", data_result, e.res);
          chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
        end
      end else if (sb.size() != 0 && sb[0].rdy_cyc < cyc) begin
        e = sb.pop_front();
        checks++; failures++;
        $display("FAIL rdy_missing cyc=%0d actual=0 expected_at=%0d", cyc, e.rdy_cyc);
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] da[6] = '{32'd100, 32'hFFFFFF9C, 32'd7, 32'd5, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] db[6] = '{32'd7, 32'd7, 32'hFFFFFF9C, 32'd0, 32'hFFFFFFFF, 32'd1};
    logic [31:0] dr[6] = '{32'd14, 32'hFFFFFFF2, 32'd0, 32'd0, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] x, y;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    mon_en = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      start(da[i], db[i]);
      wait_idle();
      chk("directed_hold", data_result, dr[i]);
    end
    start(32'd1000, 32'd10);
    repeat (9) tick();
    start(32'd81, 32'd9);
    wait_idle();
    chk("restart_result", data_result, 32'd9);
    start(32'd123456, 32'd3);
    repeat (14) tick();
    do_reset();
    @(negedge clock);
    chk("abort_result", data_result, 32'd0);
    chk("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    start(32'd42, 32'd6);
    wait_idle();
    chk("after_abort", data_result, 32'd7);
    start(32'hFFFFFC18, 32'd3);
    wait_rdy();
    start(32'd9, 32'd0);
    wait_rdy();
    start(32'd77, 32'hFFFFFFF5);
    wait_idle();
    for (int i = 0; i < 200; i++) begin
      x = ($urandom_range(0, 3) == 0) ? 32'($signed(16'($urandom))) : 32'($urandom);
      case ($urandom_range(0, 9))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = -32'($urandom_range(1, 15));
        3:       y = 32'hFFFFFFFF;
        4:       y = 32'h80000000;
        default: y = $urandom;
      endcase
      start(x, y);
      case ($urandom_range(0, 7))
        0:       repeat ($urandom_range(0, 30)) tick();
        1:       wait_rdy();
        default: wait_idle();
      endcase
    end
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
